// File: rtl/div_pkg.sv
// Shared types for the shared divider: op encoding, scheduler states and the
// nominal request-to-response latency at the default 32-bit width.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_MOD  = 2'd2,
        OP_MODU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_LATENCY       = DIV_WIDTH_DEFAULT + 1;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == OP_MOD) || (op == OP_MODU);
    endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle.
// quotient_o/remainder_o carry the step result and are final when done_o is high.
module div_radix2_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  done_o
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic                  busy;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] dsr;

    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   diff;
    logic                  q_bit;

    // A borrow out of the trial subtraction means the divisor did not fit.
    always_comb begin
        rem_sh      = {rem, quo[DATA_WIDTH-1]};
        diff        = rem_sh - {1'b0, dsr};
        q_bit       = ~diff[DATA_WIDTH];
        remainder_o = q_bit ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
        quotient_o  = {quo[DATA_WIDTH-2:0], q_bit};
    end

    assign done_o = busy && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (abort_i) begin
            busy <= 1'b0;
        end else if (start_i) begin
            busy <= 1'b1;
            cnt  <= CW'(DATA_WIDTH - 1);
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            quo <= dividend_i;
            rem <= '0;
            dsr <= divisor_i;
        end else if (busy) begin
            quo <= quotient_o;
            rem <= remainder_o;
        end
    end

endmodule

// File: rtl/div_share_scheduler.sv
// Round-robin owner of one shared radix-2 divider across the backend pipes:
// arbitration, sign handling, abort on pipe clear, and per-pipe stall requests.
module div_share_scheduler
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REQ_NUM    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    input  logic [REQ_NUM*2-1:0]          req_op_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_a_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_b_i,
    input  logic [REQ_NUM-1:0]            clr_i,
    output logic [REQ_NUM-1:0]            stall_req_o,
    output logic [REQ_NUM-1:0]            resp_valid_o,
    output logic [DATA_WIDTH-1:0]         resp_data_o,
    input  logic [REQ_NUM-1:0]            resp_ready_i,
    output logic                          busy_o
);

    localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    div_state_t                   state;
    logic [PW-1:0]                rr_ptr;
    logic [PW-1:0]                owner;
    div_op_t                      op_q;
    logic signed [DATA_WIDTH-1:0] a_q;
    logic signed [DATA_WIDTH-1:0] b_q;

    logic [REQ_NUM-1:0]           eligible;
    logic                         grant_vld;
    logic [PW-1:0]                grant_idx;
    logic [PW-1:0]                ptr_next;
    div_op_t                      sel_op;
    logic signed [DATA_WIDTH-1:0] sel_a;
    logic signed [DATA_WIDTH-1:0] sel_b;
    logic                         core_start;
    logic                         core_abort;
    logic [DATA_WIDTH-1:0]        core_quo;
    logic [DATA_WIDTH-1:0]        core_rem;
    logic                         core_done;
    logic [REQ_NUM-1:0]           owner_onehot;

    function automatic logic [DATA_WIDTH-1:0] magnitude(
        input logic signed [DATA_WIDTH-1:0] v,
        input logic                         is_signed
    );
        return (is_signed && v[DATA_WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Divide by zero bypasses sign fix-up so the quotient stays all ones.
    function automatic logic [DATA_WIDTH-1:0] sign_correct(
        input div_op_t                      op,
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b,
        input logic [DATA_WIDTH-1:0]        q_mag,
        input logic [DATA_WIDTH-1:0]        r_mag
    );
        logic q_neg;
        logic r_neg;
        logic [DATA_WIDTH-1:0] q;
        logic [DATA_WIDTH-1:0] r;
        q_neg = op_is_signed(op) && (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
        r_neg = op_is_signed(op) && a[DATA_WIDTH-1];
        q     = q_neg ? (~q_mag + 1'b1) : q_mag;
        r     = r_neg ? (~r_mag + 1'b1) : r_mag;
        if (b == '0) begin
            q = '1;
            r = a;
        end
        return op_is_rem(op) ? r : q;
    endfunction

    // Search starts at the pointer, so the pointer side wins a tie.
    always_comb begin
        eligible  = req_valid_i & ~clr_i;
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % REQ_NUM;
            if (eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(idx);
            end
        end
        ptr_next = PW'((int'(grant_idx) + 1) % REQ_NUM);
    end

    assign sel_op       = div_op_t'(req_op_i[grant_idx*2 +: 2]);
    assign sel_a        = req_a_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_b        = req_b_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign core_start   = (state == ST_IDLE) && grant_vld;
    assign core_abort   = (state == ST_CALC) && clr_i[owner];
    assign owner_onehot = REQ_NUM'(1) << owner;
    assign stall_req_o  = req_valid_i & ~resp_valid_o;

    div_radix2_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .start_i     (core_start),
        .abort_i     (core_abort),
        .dividend_i  (magnitude(sel_a, op_is_signed(sel_op))),
        .divisor_i   (magnitude(sel_b, op_is_signed(sel_op))),
        .quotient_o  (core_quo),
        .remainder_o (core_rem),
        .done_o      (core_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            op_q         <= OP_DIV;
            resp_valid_o <= '0;
            resp_data_o  <= '0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        owner  <= grant_idx;
                        op_q   <= sel_op;
                        rr_ptr <= ptr_next;
                        busy_o <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (clr_i[owner]) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (core_done) begin
                        resp_valid_o <= owner_onehot;
                        resp_data_o  <= sign_correct(op_q, a_q, b_q, core_quo, core_rem);
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (clr_i[owner] || resp_ready_i[owner]) begin
                        resp_valid_o <= '0;
                        busy_o       <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_o <= '0;
                    busy_o       <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (core_start) begin
            a_q <= sel_a;
            b_q <= sel_b;
        end
    end

endmodule

// File: tb/tb_div_share_scheduler.sv
// Randomized and directed checks of the shared divider scheduler against a
// plain-arithmetic reference model and a round-robin pointer model.
module tb_div_share_scheduler;
    import div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid_i;
    logic [3:0]    req_op_i;
    logic [63:0]   req_a_i;
    logic [63:0]   req_b_i;
    logic [1:0]    clr_i;
    logic [1:0]    stall_req_o;
    logic [1:0]    resp_valid_o;
    logic [W-1:0]  resp_data_o;
    logic [1:0]    resp_ready_i;
    logic          busy_o;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    typedef struct {
        div_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    div_share_scheduler #(.DATA_WIDTH(W), .REQ_NUM(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .clr_i        (clr_i),
        .stall_req_o  (stall_req_o),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_ready_i (resp_ready_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        case (op)
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_MODU: return (b == 0) ? a : a % b;
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sr = sa % sb;
                return sr;
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int p, input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        req_op_i[p*2 +: 2]  = op;
        req_a_i[p*32 +: 32] = a;
        req_b_i[p*32 +: 32] = b;
        req_valid_i[p]      = 1'b1;
    endtask

    task automatic wait_resp(output int cyc, output logic [1:0] v, output logic [31:0] d);
        cyc = -1;
        v   = 2'b00;
        d   = '0;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid_o != 2'b00) begin
                cyc = n;
                v   = resp_valid_o;
                d   = resp_data_o;
                return;
            end
            checks++;
            if (stall_req_o !== req_valid_i) begin
                errors++;
                $display("FAIL stall_wait cycle %0d: got %b want %b", n, stall_req_o, req_valid_i);
            end
        end
    endtask

    task automatic run_single(input int p, input div_op_t op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_d);
        int          cyc;
        logic [1:0]  v;
        logic [1:0]  exp_v;
        logic [31:0] d;
        exp_v    = 2'b00;
        exp_v[p] = 1'b1;
        set_req(p, op, a, b);
        wait_resp(cyc, v, d);
        checks++;
        if (cyc != LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d want %0d", cyc, LAT);
        end
        checks++;
        if (v !== exp_v) begin
            errors++;
            $display("FAIL single_valid: got %b want %b", v, exp_v);
        end
        checks++;
        if (d !== exp_d) begin
            errors++;
            $display("FAIL single_data %s %h/%h pipe %0d: got %h want %h", op.name(), a, b, p, d, exp_d);
        end
        checks++;
        if (busy_o !== 1'b1 || stall_req_o[p] !== 1'b0) begin
            errors++;
            $display("FAIL single_done_flags: busy %b stall %b want busy 1 stall 0", busy_o, stall_req_o[p]);
        end
        req_valid_i[p] = 1'b0;
        ptr_m = 1 - p;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (resp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: resp_valid %b busy %b want 00 0", resp_valid_o, busy_o);
        end
    endtask

    task automatic run_pair();
        int          first;
        int          second;
        int          cyc;
        logic [1:0]  v;
        logic [31:0] d;
        div_op_t     op[2];
        logic [31:0] a[2];
        logic [31:0] b[2];
        first  = ptr_m;
        second = 1 - first;
        for (int p = 0; p < 2; p++) begin
            op[p] = div_op_t'(2'($urandom_range(0, 3)));
            a[p]  = rand_operand();
            b[p]  = rand_operand();
            set_req(p, op[p], a[p], b[p]);
        end
        wait_resp(cyc, v, d);
        checks++;
        if (cyc != LAT || v !== 2'(1 << first)) begin
            errors++;
            $display("FAIL pair_first: cycle %0d valid %b want cycle %0d valid %b", cyc, v, LAT, 2'(1 << first));
        end
        checks++;
        if (d !== model(op[first], a[first], b[first])) begin
            errors++;
            $display("FAIL pair_first_data: got %h want %h", d, model(op[first], a[first], b[first]));
        end
        checks++;
        if (stall_req_o !== 2'(1 << second)) begin
            errors++;
            $display("FAIL pair_stall_other: got %b want %b", stall_req_o, 2'(1 << second));
        end
        req_valid_i[first] = 1'b0;
        ptr_m = second;
        wait_resp(cyc, v, d);
        checks++;
        if (cyc != LAT + 1 || v !== 2'(1 << second)) begin
            errors++;
            $display("FAIL pair_second: cycle %0d valid %b want cycle %0d valid %b", cyc, v, LAT + 1, 2'(1 << second));
        end
        checks++;
        if (d !== model(op[second], a[second], b[second])) begin
            errors++;
            $display("FAIL pair_second_data: got %h want %h", d, model(op[second], a[second], b[second]));
        end
        req_valid_i[second] = 1'b0;
        ptr_m = first;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (stall_req_o !== 2'b00 || resp_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: stall %b resp_valid %b want 00 00", stall_req_o, resp_valid_o);
        end
        checks++;
        if (resp_data_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: data %h busy %b want 0 0", resp_data_o, busy_o);
        end
        rst   = 1'b0;
        ptr_m = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_pair();
        run_pair();
    endtask

    task automatic test_directed();
        vec_t tbl[14];
        tbl = '{
            '{OP_DIVU, 32'd100,        32'd7,          32'd14},
            '{OP_MODU, 32'd100,        32'd7,          32'd2},
            '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
            '{OP_MOD,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
            '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
            '{OP_MOD,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0},
            '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF},
            '{OP_MODU, 32'd5,          32'd0,          32'd5},
            '{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF},
            '{OP_MOD,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB},
            '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD},
            '{OP_MOD,  32'd7,          32'hFFFF_FFFE,  32'd1},
            '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF},
            '{OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000}
        };
        for (int i = 0; i < 14; i++) begin
            run_single(0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int          p;
            div_op_t     op;
            logic [31:0] a;
            logic [31:0] b;
            p  = int'($urandom_range(0, 1));
            op = div_op_t'(2'($urandom_range(0, 3)));
            a  = rand_operand();
            b  = rand_operand();
            run_single(p, op, a, b, model(op, a, b));
        end
    endtask

    task automatic test_abort();
        int          own;
        int          oth;
        int          cyc;
        logic [1:0]  v;
        logic [31:0] d;
        own = ptr_m;
        oth = 1 - own;
        set_req(own, OP_DIVU, 32'd1000, 32'd3);
        set_req(oth, OP_MODU, 32'd1000, 32'd7);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (busy_o !== 1'b1 || resp_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL abort_pre: busy %b resp_valid %b want 1 00", busy_o, resp_valid_o);
        end
        clr_i[own]       = 1'b1;
        req_valid_i[own] = 1'b0;
        ptr_m            = oth;
        @(posedge clk);
        @(negedge clk);
        clr_i = 2'b00;
        checks++;
        if (busy_o !== 1'b0 || resp_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle: busy %b resp_valid %b want 0 00", busy_o, resp_valid_o);
        end
        wait_resp(cyc, v, d);
        checks++;
        if (cyc != LAT || v !== 2'(1 << oth)) begin
            errors++;
            $display("FAIL abort_next_grant: cycle %0d valid %b want cycle %0d valid %b", cyc, v, LAT, 2'(1 << oth));
        end
        checks++;
        if (d !== 32'd6) begin
            errors++;
            $display("FAIL abort_next_data: got %h want %h", d, 32'd6);
        end
        req_valid_i[oth] = 1'b0;
        ptr_m = own;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_req(0, OP_DIVU, 32'd12345, 32'd11);
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst         = 1'b1;
        req_valid_i = 2'b00;
        #1;
        checks++;
        if (busy_o !== 1'b0 || resp_valid_o !== 2'b00 || stall_req_o !== 2'b00 || resp_data_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy %b resp_valid %b stall %b data %h want all 0",
                     busy_o, resp_valid_o, stall_req_o, resp_data_o);
        end
        @(negedge clk);
        rst   = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        run_single(1, OP_DIVU, 32'd12345, 32'd11, 32'd1122);
        ptr_m = 0;
        // pointer reset plus one pipe-1 grant leaves it at pipe 0 again
        run_pair();
    endtask

    initial begin
        rst          = 1'b1;
        req_valid_i  = 2'b00;
        req_op_i     = '0;
        req_a_i      = '0;
        req_b_i      = '0;
        clr_i        = 2'b00;
        resp_ready_i = 2'b11;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_directed();
        test_random();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
